mem_split: RTL and testbench
============================

# mem_split

Address decoder that connects one memory master to three memory slaves. It is the split-side counterpart of the two-master arbiter and sits between the CPU (or arbiter output) and the RAM, ROM and peripheral buses. Each request is decoded by address, routed to exactly one downstream port, and completed with that port's handshake. Unmapped addresses and stalled slaves get a deterministic error response, so the master never hangs.

## Interface
- BASE0, 32'h0000_0000, port 0 match value
- MASK0, 32'hFFFF_0000, port 0 address mask
- BASE1, 32'h0001_0000, port 1 match value
- MASK1, 32'hFFFF_0000, port 1 address mask
- BASE2, 32'h8000_0000, port 2 match value
- MASK2, 32'hF000_0000, port 2 address mask
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on error completion
- TIMEOUT, 256, max BUSY cycles before forced error; 0 disables the timeout; legal range 0..65535

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_valid  in  1  upstream request; held until mem_ready
- mem_ready  out  1  upstream completion, one-cycle pulse
- mem_addr  in  32  upstream address
- mem_rdata  out  32  upstream read data, valid when mem_ready=1
- mem_wdata  in  32  upstream write data
- mem_wstrb  in  4  upstream byte strobes; 0 = read
- mem_err  out  1  high with mem_ready when the completion is an error
- memK_valid  out  1  downstream request, K = 0,1,2
- memK_ready  in  1  downstream completion
- memK_addr  out  32  downstream address (mem_addr broadcast)
- memK_rdata  in  32  downstream read data
- memK_wdata  out  32  downstream write data (mem_wdata broadcast)
- memK_wstrb  out  4  mem_wstrb when port K is selected, else 0

## Operation
- States: IDLE, BUSY, ERR. State is held in a 2-bit register; sel is a 2-bit register; cnt is a 16-bit counter.
- Decode: hitK = ((mem_addr & MASKK) == BASEK). The lowest K wins on overlap. No hit means unmapped.
- IDLE with mem_valid=1:
  - On a hit, go to BUSY and set sel=K, cnt=0.
  - On a miss, go to ERR.
  - With mem_valid=0, stay in IDLE.
- BUSY:
  - memSEL_valid=1; all other memK_valid=0.
  - mem_ready = memSEL_ready, combinational.
  - mem_rdata = memSEL_rdata, combinational.
  - When memSEL_ready=1, go to IDLE.
  - Otherwise cnt increments. If TIMEOUT≠0 and cnt==TIMEOUT-1, go to ERR.
- ERR (exactly one cycle):
  - mem_ready=1, mem_err=1, mem_rdata=ERR_DATA, all memK_valid=0.
  - Next state is IDLE.
- IDLE outputs: mem_ready=0, mem_err=0, mem_rdata=0, all memK_valid=0.
- A downstream ready outside BUSY, or on a non-selected port, is ignored.
- A late ready from a timed-out port is ignored.
- The upstream master must hold addr, wdata and wstrb stable until mem_ready. If mem_valid drops mid-BUSY, the block still completes the transaction; no abort.
- Reset (any time, including mid-BUSY):
  - State goes to IDLE, sel=0, cnt=0.
  - All memK_valid=0, mem_ready=0, mem_err=0, mem_rdata=0.
  - A downstream transaction cut by reset is abandoned.

## Timing
- The request accepted in IDLE at cycle N gives memK_valid=1 at cycle N+1. Decode is registered, so there is one cycle of added latency.
- With a zero-wait slave (memK_ready=1 at N+1), mem_ready=1 at N+1. Total latency is 2 cycles including the accept cycle.
- Back-to-back requests have at least one IDLE cycle between completions. A master that keeps mem_valid high after mem_ready starts its next request at the cycle following mem_ready.
- Unmapped request accepted at N gives mem_ready=mem_err=1 at N+1.
- Timeout: for a BUSY entry at N+1 with no ready, memK_valid is high for cycles N+1..N+TIMEOUT. The error completion occurs at N+TIMEOUT+1.
- A ready in the same cycle as cnt==TIMEOUT-1 wins: normal completion, mem_err=0.
- mem_ready and mem_err are never high for more than one consecutive cycle.

## Test plan
- Reset: hold rst=0 with mem_valid=1 -> every output is 0. Release -> first accept on the next edge.
- Read to 0x0000_0010, port 0 ready immediately with rdata 0x1234_5678 -> mem0_valid one cycle, mem_rdata=0x1234_5678, mem_ready at accept+1, mem_err=0, mem1/2_valid=0.
- Write 0x8000_0004 wstrb=4'b0011, port 2 ready after 3 wait cycles -> mem2_wstrb=4'b0011, mem0/1_wstrb=0, mem_ready at accept+4.
- Unmapped 0x4000_0000 -> no memK_valid, mem_ready=mem_err=1, mem_rdata=0xDEADBEEF at accept+1.
- TIMEOUT=4, port 1 never ready -> mem1_valid high for 4 cycles, then a 1-cycle error completion. A mem1_ready one cycle later is ignored. A ready at exactly the 4th BUSY cycle instead gives a normal completion.
- Assert rst=0 mid-BUSY on port 1, then deassert, then request 0x0001_0000 -> clean restart, sel=1, normal completion.

Source files
------------

// File: rtl/mem_split.sv
// rtl/mem_split.sv - one-master to three-slave address-decoding memory splitter
//
// Purpose: decodes each upstream request by address, forwards it to exactly
// one downstream port (0 = lowest-numbered match wins) and returns that port's
// completion. Unmapped addresses and slaves that stay busy for TIMEOUT cycles
// complete with a one-cycle error response carrying ERR_DATA.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   mem_valid/ready/addr/rdata/
//   mem_wdata/wstrb/err           upstream master side (wstrb == 0 is a read)
//   memK_valid/ready/addr/rdata/
//   memK_wdata/wstrb  (K=0,1,2)   downstream slave sides; addr/wdata are
//                                 broadcast, wstrb only to the selected port
module mem_split #(
    parameter logic [31:0] BASE0    = 32'h0000_0000,
    parameter logic [31:0] MASK0    = 32'hFFFF_0000,
    parameter logic [31:0] BASE1    = 32'h0001_0000,
    parameter logic [31:0] MASK1    = 32'hFFFF_0000,
    parameter logic [31:0] BASE2    = 32'h8000_0000,
    parameter logic [31:0] MASK2    = 32'hF000_0000,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
    parameter int          TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_err,
    output logic        mem0_valid,
    input  logic        mem0_ready,
    output logic [31:0] mem0_addr,
    input  logic [31:0] mem0_rdata,
    output logic [31:0] mem0_wdata,
    output logic [3:0]  mem0_wstrb,
    output logic        mem1_valid,
    input  logic        mem1_ready,
    output logic [31:0] mem1_addr,
    input  logic [31:0] mem1_rdata,
    output logic [31:0] mem1_wdata,
    output logic [3:0]  mem1_wstrb,
    output logic        mem2_valid,
    input  logic        mem2_ready,
    output logic [31:0] mem2_addr,
    input  logic [31:0] mem2_rdata,
    output logic [31:0] mem2_wdata,
    output logic [3:0]  mem2_wstrb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Last BUSY cycle index before the forced error; unused when TIMEOUT == 0.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  sel;
    logic [15:0] cnt;

    logic        hit0, hit1, hit2, hit_any;
    logic [1:0]  hit_sel;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic [2:0]  port_valid;

    assign hit0    = (mem_addr & MASK0) == BASE0;
    assign hit1    = (mem_addr & MASK1) == BASE1;
    assign hit2    = (mem_addr & MASK2) == BASE2;
    assign hit_any = hit0 | hit1 | hit2;
    assign hit_sel = hit0 ? 2'd0 : (hit1 ? 2'd1 : 2'd2);

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'h0;
        case (sel)
            2'd0: begin sel_ready = mem0_ready; sel_rdata = mem0_rdata; end
            2'd1: begin sel_ready = mem1_ready; sel_rdata = mem1_rdata; end
            2'd2: begin sel_ready = mem2_ready; sel_rdata = mem2_rdata; end
            default: begin sel_ready = 1'b0; sel_rdata = 32'h0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            cnt   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        if (hit_any) begin
                            state <= BUSY;
                            sel   <= hit_sel;
                            cnt   <= 16'd0;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    // A ready on the final counted cycle beats the timeout.
                    if (sel_ready) begin
                        state <= IDLE;
                    end else if (TIMEOUT != 0 && cnt == TIMEOUT_LAST) begin
                        state <= ERR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_ready  = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = 32'h0;
        port_valid = 3'b000;
        case (state)
            BUSY: begin
                mem_ready = sel_ready;
                mem_rdata = sel_rdata;
                case (sel)
                    2'd0:    port_valid = 3'b001;
                    2'd1:    port_valid = 3'b010;
                    2'd2:    port_valid = 3'b100;
                    default: port_valid = 3'b000;
                endcase
            end
            ERR: begin
                mem_ready = 1'b1;
                mem_err   = 1'b1;
                mem_rdata = ERR_DATA;
            end
            default: ;
        endcase
    end

    assign mem0_valid = port_valid[0];
    assign mem1_valid = port_valid[1];
    assign mem2_valid = port_valid[2];

    assign mem0_addr  = mem_addr;
    assign mem1_addr  = mem_addr;
    assign mem2_addr  = mem_addr;
    assign mem0_wdata = mem_wdata;
    assign mem1_wdata = mem_wdata;
    assign mem2_wdata = mem_wdata;

    assign mem0_wstrb = port_valid[0] ? mem_wstrb : 4'b0000;
    assign mem1_wstrb = port_valid[1] ? mem_wstrb : 4'b0000;
    assign mem2_wstrb = port_valid[2] ? mem_wstrb : 4'b0000;

endmodule

// File: tb/tb_mem_split.sv
// tb/tb_mem_split.sv - directed scoreboard bench for mem_split
module tb_mem_split;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_err;
    logic        mem0_valid, mem1_valid, mem2_valid;
    logic        mem0_ready, mem1_ready, mem2_ready;
    logic [31:0] mem0_addr, mem1_addr, mem2_addr;
    logic [31:0] mem0_rdata, mem1_rdata, mem2_rdata;
    logic [31:0] mem0_wdata, mem1_wdata, mem2_wdata;
    logic [3:0]  mem0_wstrb, mem1_wstrb, mem2_wstrb;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_split #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_err(mem_err),
        .mem0_valid(mem0_valid), .mem0_ready(mem0_ready), .mem0_addr(mem0_addr),
        .mem0_rdata(mem0_rdata), .mem0_wdata(mem0_wdata), .mem0_wstrb(mem0_wstrb),
        .mem1_valid(mem1_valid), .mem1_ready(mem1_ready), .mem1_addr(mem1_addr),
        .mem1_rdata(mem1_rdata), .mem1_wdata(mem1_wdata), .mem1_wstrb(mem1_wstrb),
        .mem2_valid(mem2_valid), .mem2_ready(mem2_ready), .mem2_addr(mem2_addr),
        .mem2_rdata(mem2_rdata), .mem2_wdata(mem2_wdata), .mem2_wstrb(mem2_wstrb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_valids(input string tag, input logic [2:0] exp);
        chk({tag, "_valids"}, {29'd0, mem2_valid, mem1_valid, mem0_valid}, {29'd0, exp});
    endtask

    // Called at a sample point where a completion is expected.
    task automatic complete_check(input string tag);
        exp_t e;
        chk({tag, "_ready"}, {31'd0, mem_ready}, 32'd1);
        chk({tag, "_sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, mem_rdata, e.rdata);
            chk({tag, "_err"}, {31'd0, mem_err}, {31'd0, e.err});
        end
    endtask

    task automatic check_idle_out(input string tag);
        chk({tag, "_ready0"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, "_err0"}, {31'd0, mem_err}, 32'd0);
        chk({tag, "_rdata0"}, mem_rdata, 32'd0);
        check_valids(tag, 3'b000);
    endtask

    initial begin
        rst        = 1'b0;
        mem_valid  = 1'b1;
        mem_addr   = 32'h0000_0010;
        mem_wdata  = 32'h0;
        mem_wstrb  = 4'b0000;
        mem0_ready = 1'b0; mem1_ready = 1'b0; mem2_ready = 1'b0;
        mem0_rdata = 32'h0; mem1_rdata = 32'h0; mem2_rdata = 32'h0;

        // Reset held with a pending request: everything stays quiet.
        repeat (3) step();
        sample();
        check_idle_out("reset");
        chk("reset_wstrb", {20'd0, mem0_wstrb, mem1_wstrb, mem2_wstrb}, 32'd0);

        // Read port 0, zero-wait slave: accept at N, completion at N+1.
        step();
        rst = 1'b1;
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        sample();
        check_idle_out("rd0_accept");
        step();
        mem0_ready = 1'b1;
        mem0_rdata = 32'h1234_5678;
        sample();
        check_valids("rd0_busy", 3'b001);
        complete_check("rd0");
        step();
        mem_valid  = 1'b0;
        mem0_ready = 1'b0;
        sample();
        check_idle_out("rd0_after");

        // Write port 2 with 3 wait cycles: completion at accept+4.
        step();
        mem_valid  = 1'b1;
        mem_addr   = 32'h8000_0004;
        mem_wdata  = 32'hA5A5_0001;
        mem_wstrb  = 4'b0011;
        mem2_rdata = 32'hCAFE_0002;
        sb.push_back('{rdata: 32'hCAFE_0002, err: 1'b0});
        for (int i = 1; i <= 3; i++) begin
            step();
            sample();
            check_valids("wr2_wait", 3'b100);
            chk("wr2_wait_ready", {31'd0, mem_ready}, 32'd0);
            chk("wr2_wstrb2", {28'd0, mem2_wstrb}, 32'h3);
            chk("wr2_wstrb01", {24'd0, mem0_wstrb, mem1_wstrb}, 32'd0);
            chk("wr2_wdata", mem2_wdata, 32'hA5A5_0001);
        end
        step();
        mem2_ready = 1'b1;
        sample();
        complete_check("wr2");
        step();
        mem_valid  = 1'b0;
        mem_wstrb  = 4'b0000;
        mem2_ready = 1'b0;
        sample();
        check_idle_out("wr2_after");

        // Unmapped: error at accept+1, no downstream request.
        step();
        mem_valid = 1'b1;
        mem_addr  = 32'h4000_0000;
        sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b1});
        step();
        sample();
        check_valids("unmap", 3'b000);
        complete_check("unmap");
        step();
        mem_valid = 1'b0;
        sample();
        check_idle_out("unmap_after");

        // Port 1 never ready: 4 BUSY cycles then one error cycle.
        step();
        mem_valid = 1'b1;
        mem_addr  = 32'h0001_0000;
        sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b1});
        for (int i = 1; i <= 4; i++) begin
            step();
            sample();
            check_valids("to_busy", 3'b010);
            chk("to_busy_ready", {31'd0, mem_ready}, 32'd0);
        end
        step();
        sample();
        check_valids("to_err", 3'b000);
        complete_check("to_err");
        step();
        mem_valid  = 1'b0;
        mem1_ready = 1'b1;
        mem1_rdata = 32'h5555_AAAA;
        sample();
        check_idle_out("to_late_ready");
        step();
        mem1_ready = 1'b0;
        sample();
        check_idle_out("to_after");

        // Ready on the 4th BUSY cycle beats the timeout.
        step();
        mem_valid  = 1'b1;
        mem_addr   = 32'h0001_0004;
        mem1_rdata = 32'h0BAD_F00D;
        sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
        for (int i = 1; i <= 3; i++) begin
            step();
            sample();
            check_valids("race_busy", 3'b010);
        end
        step();
        mem1_ready = 1'b1;
        sample();
        complete_check("race");
        step();
        mem_valid  = 1'b0;
        mem1_ready = 1'b0;
        sample();
        check_idle_out("race_after");

        // Reset mid-BUSY on port 1, then a clean restart to port 1.
        step();
        mem_valid = 1'b1;
        mem_addr  = 32'h0001_0000;
        step();
        sample();
        check_valids("rstb_busy", 3'b010);
        #2;
        rst = 1'b0;
        #1;
        check_idle_out("rstb_inreset");
        step();
        rst        = 1'b1;
        mem1_rdata = 32'h1111_2222;
        sb.push_back('{rdata: 32'h1111_2222, err: 1'b0});
        sample();
        check_idle_out("rstb_idle");
        step();
        mem1_ready = 1'b1;
        sample();
        check_valids("rstb_restart", 3'b010);
        complete_check("rstb_restart");
        step();
        mem_valid  = 1'b0;
        mem1_ready = 1'b0;
        sample();
        check_idle_out("rstb_after");

        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
